// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage constants: default address window and fetch FSM states.
package ifu_fetch_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_pc_range_check.sv
// Combinational instruction-address check: flags misaligned or out-of-window words (AdEL).
module ifu_fetch_pc_range_check
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic [31:0] addr,
  output logic        adel
);

  assign adel = (addr[1:0] != 2'b00) || (addr < PC_BASE) || (addr > PC_LIMIT);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, F/D register fill.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic        D_valid,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic        D_exc
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc, pend_pc, skid_instr, next_pc, deliver_instr;
  logic        pend_valid, skid_valid, redirect_ok;
  logic        pc_adel, next_adel;
  logic        deliver, deliver_exc, skid_load, req_raw;

  assign redirect_ok = redirect & ~D_stall;
  assign next_pc     = redirect_ok ? redirect_pc : (pend_valid ? pend_pc : pc + 32'd4);
  assign F_PC        = pc;

  ifu_fetch_pc_range_check #(.PC_BASE(PC_BASE), .PC_LIMIT(PC_LIMIT)) u_pc_chk (
    .addr (pc),
    .adel (pc_adel)
  );

  ifu_fetch_pc_range_check #(.PC_BASE(PC_BASE), .PC_LIMIT(PC_LIMIT)) u_next_chk (
    .addr (next_pc),
    .adel (next_adel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ISSUE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ISSUE: if (!D_stall && !skid_valid && !pc_adel) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (D_stall)        state_nxt = ST_HOLD;
          else if (next_adel) state_nxt = ST_ISSUE;
        end
      end
      ST_HOLD:  if (!D_stall) state_nxt = next_adel ? ST_ISSUE : ST_WAIT;
      default:  state_nxt = ST_ISSUE;
    endcase
  end

  // pc always names the instruction not yet handed to D; it advances exactly on delivery.
  always_comb begin
    req_raw       = 1'b0;
    imem_addr     = pc;
    deliver       = 1'b0;
    deliver_instr = '0;
    deliver_exc   = 1'b0;
    skid_load     = 1'b0;
    unique case (state)
      ST_ISSUE: begin
        if (!D_stall && !skid_valid) begin
          if (pc_adel) begin
            deliver     = 1'b1;
            deliver_exc = 1'b1;
          end else begin
            req_raw = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (D_stall) begin
            skid_load = 1'b1;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            req_raw       = ~next_adel;
            imem_addr     = next_pc;
          end
        end
      end
      ST_HOLD: begin
        if (!D_stall) begin
          deliver       = 1'b1;
          deliver_instr = skid_instr;
          req_raw       = ~next_adel;
          imem_addr     = next_pc;
        end
      end
      default: ;
    endcase
    imem_req = req_raw & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= PC_RESET;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      D_valid    <= 1'b0;
      D_instr    <= '0;
      D_pc       <= '0;
      D_exc      <= 1'b0;
    end else begin
      if (deliver) begin
        pc         <= next_pc;
        pend_valid <= 1'b0;
      end else if (redirect_ok) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
      if (skid_load) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
      end else if (deliver) begin
        skid_valid <= 1'b0;
      end
      if (deliver) begin
        D_valid <= 1'b1;
        D_instr <= deliver_instr;
        D_pc    <= pc;
        D_exc   <= deliver_exc;
      end else if (!D_stall) begin
        D_valid <= 1'b0;
        D_exc   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and randomized bench for ifu_fetch with a delivery-order reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RST   = 32'h0000_3000;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        D_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] F_PC;
  logic        D_valid;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic        D_exc;

  ifu_fetch #(.PC_RESET(RST), .PC_BASE(BASE), .PC_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .D_stall     (D_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .F_PC        (F_PC),
    .D_valid     (D_valid),
    .D_instr     (D_instr),
    .D_pc        (D_pc),
    .D_exc       (D_exc)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference: program-order next address, one word in flight, one word parked while stalled.
  logic [31:0] m_pc = RST, m_pend = '0, m_held = '0;
  bit          m_pend_v = 1'b0, m_out = 1'b0, m_held_v = 1'b0;
  bit          e_valid = 1'b0, e_exc = 1'b0;
  logic [31:0] e_instr = '0, e_pc = '0;

  bit          mem_busy = 1'b0;
  int unsigned mem_cnt = 0, lat = 1;
  logic [31:0] mem_addr = '0;
  bit          stray = 1'b0;
  logic [31:0] dpc_log[$];

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a <= LIMIT);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_d(input logic [31:0] instr, input logic [31:0] pc, input bit exc);
    e_valid = 1'b1;
    e_instr = instr;
    e_pc    = pc;
    e_exc   = exc;
  endtask

  task automatic do_reset();
    reset = 1'b0; D_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    #1;
    chk1("rst_D_valid", D_valid, 1'b0);
    chk32("rst_D_instr", D_instr, 32'h0);
    chk32("rst_D_pc", D_pc, 32'h0);
    chk1("rst_D_exc", D_exc, 1'b0);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk32("rst_F_PC", F_PC, RST);
    m_pc = RST; m_pend_v = 1'b0; m_out = 1'b0; m_held_v = 1'b0;
    e_valid = 1'b0; mem_busy = 1'b0; stray = 1'b0;
    #1 reset = 1'b1;
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit rv, rok, adv, exc_d, iss;
    logic [31:0] rw, nxt, npc, old_pc;
    rv = (mem_busy && mem_cnt == 1) || stray;
    rw = stray ? 32'hDEAD_BEEF : word_at(mem_addr);
    D_stall = st; redirect = rd; redirect_pc = rpc; imem_rvalid = rv; imem_rdata = rw;
    rok    = rd && !st;
    old_pc = m_pc;
    nxt    = rok ? rpc : (m_pend_v ? m_pend : m_pc + 32'd4);
    adv = 1'b0; exc_d = 1'b0;
    if (m_held_v) begin
      if (!st) begin adv = 1'b1; expect_d(m_held, m_pc, 1'b0); m_held_v = 1'b0; end
    end else if (m_out && rv) begin
      m_out = 1'b0;
      if (st) begin m_held_v = 1'b1; m_held = rw; end
      else begin adv = 1'b1; expect_d(rw, m_pc, 1'b0); end
    end else if (!m_out && !st && !legal(m_pc)) begin
      adv = 1'b1; exc_d = 1'b1; expect_d(32'h0, m_pc, 1'b1);
    end
    if (!adv && !st) e_valid = 1'b0;
    npc = adv ? nxt : m_pc;
    // An exception delivery uses up its cycle; the following fetch waits one cycle.
    iss = !st && !m_out && !m_held_v && !exc_d && legal(npc);
    if (adv) m_pend_v = 1'b0;
    else if (rok) begin m_pend_v = 1'b1; m_pend = rpc; end
    #2;
    chk32("F_PC", F_PC, old_pc);
    chk1("imem_req", imem_req, iss);
    if (iss) chk32("imem_addr", imem_addr, npc);
    @(posedge clk);
    m_pc = npc;
    if (iss) m_out = 1'b1;
    if (rv && !stray) mem_busy = 1'b0;
    if (iss) begin mem_busy = 1'b1; mem_cnt = lat; mem_addr = npc; end
    else if (mem_busy) mem_cnt--;
    stray = 1'b0;
    #1;
    chk1("D_valid", D_valid, e_valid);
    if (e_valid) begin
      chk32("D_instr", D_instr, e_instr);
      chk32("D_pc", D_pc, e_pc);
      chk1("D_exc", D_exc, e_exc);
    end
    if (!st && D_valid) dpc_log.push_back(D_pc);
  endtask

  initial begin
    bit          st, rd;
    logic [31:0] tgt;
    int unsigned sel;

    @(posedge clk); #1;

    // Free run, 1-cycle memory
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);

    // Taken beq at 0x3000 to 0x3010 while 0x3004 is outstanding
    do_reset();
    lat = 2;
    dpc_log.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_3010);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    chk32("beq_len", 32'(dpc_log.size()), 32'd3);
    if (dpc_log.size() == 3) begin
      chk32("beq_d0", dpc_log[0], 32'h0000_3000);
      chk32("beq_d1", dpc_log[1], 32'h0000_3004);
      chk32("beq_d2", dpc_log[2], 32'h0000_3010);
    end

    // Stall across a 3-cycle response, then release
    do_reset();
    lat = 3;
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk32("skid_release_instr", D_instr, word_at(32'h0000_3000));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    // jr to misaligned target, wrap past 0xFFFFFFFC, ignored redirect under stall
    do_reset();
    lat = 1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_3002);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk1("jr_exc", D_exc, 1'b1);
    chk32("jr_instr", D_instr, 32'h0);
    chk32("jr_pc", D_pc, 32'h0000_3002);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_3040);
    chk32("wrap_pc", D_pc, 32'h0);
    chk1("wrap_exc", D_exc, 1'b1);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_3080);
    step(1'b0, 1'b1, 32'h0000_3080);
    chk32("redir_after_stall", F_PC, 32'h0000_3080);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    // Reset while waiting on 0x300C, then a stale response
    do_reset();
    lat = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    lat = 3;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk32("wait_pc", F_PC, 32'h0000_300C);
    do_reset();
    stray = 1'b1;
    step(1'b1, 1'b0, '0);
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

    // Randomized stall/redirect/latency mix
    do_reset();
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 10);
      sel = $urandom_range(0, 9);
      tgt = BASE + 32'($urandom_range(0, 255)) * 32'd4;
      if (sel == 7) tgt = BASE - 32'd4;
      else if (sel == 8) tgt = tgt | 32'd2;
      else if (sel == 9) tgt = LIMIT - 32'd4;
      step(st, rd, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage for the five-stage MIPS pipeline: owns the PC register, issues word requests to a variable-latency instruction memory, and fills the F/D pipeline register. It consumes the next-PC decision made in D: redirect target and pipeline stall. It returns the current fetch PC that the next-PC logic adds 4 to. Delayed-branch semantics: the instruction in F when a redirect arrives is the delay slot and is always delivered.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, first fetch address after reset
- PC_BASE, 32'h0000_3000, lowest legal instruction address
- PC_LIMIT, 32'h0000_6FFC, highest legal instruction address

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- D_stall  in  1  freeze F/D register and suppress new requests
- redirect  in  1  D-stage control transfer taken (jr/jal/taken beq); ignored while D_stall=1
- redirect_pc  in  32  target of the control transfer
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  32  word address, valid with imem_req
- imem_rvalid  in  1  response valid, earliest one cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- F_PC  out  32  address of the instruction currently in F
- D_valid  out  1  F/D register holds an instruction
- D_instr  out  32  instruction in D
- D_pc  out  32  address of D_instr
- D_exc  out  1  D_instr is a fetch-address exception (AdEL); D_instr forced to 0

## Operation
- At most one outstanding memory request.
- Registers: pc, pend_valid/pend_pc, skid_valid/skid_instr, state.
- States:
  - ISSUE: next address available, no request outstanding.
  - WAIT: request outstanding.
  - HOLD: response captured in skid, D stalled.
- Next fetch address = redirect (same cycle, D_stall=0) ? redirect_pc : pend_valid ? pend_pc : pc+4.
- Redirect accepted in a cycle without a request issue is stored in pend; pend clears when consumed.
- ISSUE:
  - If D_stall=0 and the F slot is free, issue imem_req and go to WAIT.
  - Illegal address (addr[1:0]!=0, <PC_BASE or >PC_LIMIT): no imem_req. Deliver to D as D_instr=0, D_exc=1, D_pc=addr. Advance pc and stay in ISSUE.
- WAIT:
  - On rvalid with D_stall=0: load D (D_valid=1, D_exc=0) and issue the next request in the same cycle if legal. Stay in WAIT, or go to ISSUE if the address is illegal.
  - On rvalid with D_stall=1: capture in skid and go to HOLD.
- HOLD: when D_stall falls, move skid to D, issue the next request the same cycle, and go to WAIT.
- D_stall=1: F/D register unchanged; no new imem_req. An outstanding response is still accepted, into skid.
- D_stall=0 with no instruction ready: D_valid drops to 0 (bubble).
- F_PC = pc, the address of the outstanding, held or to-be-issued instruction.
- pc+4 wraps modulo 2^32; the wrapped value fails the range check.

## Timing
- Reset values: pc=PC_RESET, state=ISSUE, D_valid=0, D_instr=0, D_pc=0, D_exc=0, imem_req=0, pend/skid cleared.
- First imem_req (addr 0x3000) in the first cycle after reset deasserts.
- With 1-cycle memory latency and no stalls: one instruction per cycle. An instruction appears in D on the edge after its rvalid.
- Redirect latency: the target is requested in the cycle redirect is seen if a request issues then, else at the next issue.
- A simultaneous redirect and rvalid delivers the rvalid word (the delay slot) and requests redirect_pc.
- Reset asserted mid-request: a later stray rvalid is ignored while state=ISSUE with no outstanding request.

## Structure
- Shared package/header: PC_RESET, PC_BASE, PC_LIMIT and the state encodings (ISSUE, WAIT, HOLD).
- Natural sub-module: pc_range_check (combinational alignment/range test → adel flag), reusable by the data-memory stage.

## Test plan
- Reset then free-run, 1-cycle memory: imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; D_pc follows one cycle after each rvalid.
- beq at 0x3000 taken to 0x3010 (redirect while the 0x3004 request is outstanding): D sequence 0x3000, 0x3004, 0x3010.
- D_stall=1 for 3 cycles while a 3-cycle-latency response returns: word held in skid, D unchanged. On release, D_instr = held word and the next request issues the same cycle.
- jr to 0x3002: no imem_req; D_exc=1, D_instr=0, D_pc=0x3002.
- redirect asserted with D_stall=1: ignored, no pend set; reasserted next cycle with D_stall=0: accepted.
- Reset asserted during WAIT at 0x300C: outputs cleared immediately. Post-reset fetch restarts at 0x3000. Stale rvalid is dropped.
